single_port_blockram_controller: RTL

Request-side controller for one `single_port_blockram` instance. It accepts read/write requests over a valid/ack handshake and drives the blockram access port. It captures the blockram's one-cycle read data into a 2-entry response buffer that is drained under a valid/ack handshake. Sits between a cache/tag pipeline stage and the storage array; optionally zero-fills the array after reset.

---
 rtl/single_port_blockram_controller.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/single_port_blockram_controller.sv
// Request/response controller in front of one single_port_blockram.
// Zero-fill sweep after reset when SINGLE_PORT_BLOCKRAM_CONTROLLER_INIT_SWEEP_EN is defined.
module single_port_blockram_controller #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS               = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUMBER_SETS)
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  input  logic                                 request_valid_in,
  input  logic                                 request_write_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_addr_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_data_in,
  output logic                                 request_ack_out,
  output logic                                 response_valid_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_data_out,
  input  logic                                 response_ack_in,
  output logic                                 busy_out,
  output logic                                 ram_access_en_out,
  output logic                                 ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]     ram_set_addr_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_write_entry_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_read_entry_in
);

  localparam int W  = SINGLE_ENTRY_SIZE_IN_BITS;
  localparam int AW = SET_PTR_WIDTH_IN_BITS;

  logic          w_init;
  logic          w_run;
  logic [AW-1:0] w_sweep_addr;

`ifdef SINGLE_PORT_BLOCKRAM_CONTROLLER_INIT_SWEEP_EN
  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NUMBER_SETS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_sweep_ptr;
  logic [AW-1:0] w_sweep_nxt;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      r_state     <= S_INIT;
      r_sweep_ptr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_ptr <= w_sweep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_ptr;
    unique case (r_state)
      S_INIT: begin
        w_sweep_nxt = r_sweep_ptr + AW'(1);
        if (r_sweep_ptr == LAST) begin
          w_state_nxt = S_RUN;
          w_sweep_nxt = '0;
        end
      end
      S_RUN: begin
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign w_init       = (r_state == S_INIT);
  assign w_run        = (r_state == S_RUN);
  assign w_sweep_addr = r_sweep_ptr;
  // Busy is forced high while reset is held so the idle reset view matches the sweep.
  assign busy_out     = !reset_in | w_init;
`else
  assign w_init       = 1'b0;
  assign w_run        = 1'b1;
  assign w_sweep_addr = '0;
  assign busy_out     = 1'b0;
`endif

  logic          r_inflight;
  logic [1:0]    r_occ;
  logic          r_head;
  logic [W-1:0]  r_buf [2];
  logic [AW-1:0] r_addr;
  logic [W-1:0]  r_wdata;

  logic          w_pop;
  logic          w_ack;
  logic          w_rd;
  logic          w_tail;
  logic [2:0]    w_count;
  logic [2:0]    w_limit;
  logic          w_ram_en;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [W-1:0]  w_ram_data;

  assign response_valid_out = (r_occ != 2'd0);
  assign response_data_out  = r_buf[r_head];

  assign w_pop   = response_valid_out & response_ack_in;
  assign w_count = {1'b0, r_occ} + {2'b0, r_inflight};
  assign w_limit = 3'd2 + {2'b0, w_pop};
  assign w_ack   = reset_in & w_run & request_valid_in
                 & (request_write_in | (w_count < w_limit));
  assign w_rd    = w_ack & !request_write_in;
  // A push at full occupancy only happens with a pop, so it reuses the head slot.
  assign w_tail  = r_head ^ r_occ[0];

  assign request_ack_out = w_ack;

  always_comb begin
    w_ram_en   = 1'b0;
    w_ram_we   = 1'b0;
    w_ram_addr = r_addr;
    w_ram_data = r_wdata;
    if (reset_in && w_init) begin
      w_ram_en   = 1'b1;
      w_ram_we   = 1'b1;
      w_ram_addr = w_sweep_addr;
      w_ram_data = '0;
    end else if (w_ack) begin
      w_ram_en   = 1'b1;
      w_ram_we   = request_write_in;
      w_ram_addr = request_addr_in;
      w_ram_data = request_data_in;
    end
  end

  assign ram_access_en_out   = w_ram_en;
  assign ram_write_en_out    = w_ram_we;
  assign ram_set_addr_out    = w_ram_addr;
  assign ram_write_entry_out = w_ram_data;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_head     <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_inflight <= w_rd;
      r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      if (w_pop) begin
        r_head <= ~r_head;
      end
      if (r_inflight) begin
        r_buf[w_tail] <= ram_read_entry_in;
      end
      if (w_ram_en) begin
        r_addr  <= w_ram_addr;
        r_wdata <= w_ram_data;
      end
    end
  end

endmodule
